// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, pixel format and scan-out state encoding for the
// 480x272 RGB panel interface.
package lcd_timing_pkg;

  localparam int unsigned LCD_H_ACTIVE = 480;
  localparam int unsigned LCD_H_SYNC   = 4;
  localparam int unsigned LCD_H_BP     = 43;
  localparam int unsigned LCD_H_FP     = 8;
  localparam int unsigned LCD_V_ACTIVE = 272;
  localparam int unsigned LCD_V_SYNC   = 4;
  localparam int unsigned LCD_V_BP     = 12;
  localparam int unsigned LCD_V_FP     = 8;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic {
    SEEK = 1'b0,
    RUN  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/lcd_hv_counter.sv
// Free-running horizontal/vertical raster counters with decoded sync,
// active-area and frame-origin strobes for the current position.
module lcd_hv_counter
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = LCD_H_ACTIVE,
  parameter int unsigned H_SYNC   = LCD_H_SYNC,
  parameter int unsigned H_BP     = LCD_H_BP,
  parameter int unsigned H_FP     = LCD_H_FP,
  parameter int unsigned V_ACTIVE = LCD_V_ACTIVE,
  parameter int unsigned V_SYNC   = LCD_V_SYNC,
  parameter int unsigned V_BP     = LCD_V_BP,
  parameter int unsigned V_FP     = LCD_V_FP
) (
  input  logic clk,
  input  logic rst_n,
  output logic in_active,
  output logic is_fap,
  output logic hsync_n,
  output logic vsync_n,
  output logic frame0
);

  localparam int unsigned H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_FST  = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_LST  = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_FST  = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_LST  = VW'(V_SYNC + V_BP + V_ACTIVE - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end
  end

  // Decodes describe the position currently held in the counters.
  always_comb begin
    in_active = (h_q >= H_ACT_FST) && (h_q <= H_ACT_LST) &&
                (v_q >= V_ACT_FST) && (v_q <= V_ACT_LST);
    is_fap    = (h_q == H_ACT_FST) && (v_q == V_ACT_FST);
    hsync_n   = !(h_q < H_SYNC_END);
    vsync_n   = !(v_q < V_SYNC_END);
    frame0    = (h_q == '0) && (v_q == '0);
  end

endmodule

// File: rtl/lcd_rgb_scanout.sv
// LCD panel scan-out: raster timing plus a valid/ready RGB565 drain that locks
// the stream to the first active pixel and flags underrun / misalignment.
module lcd_rgb_scanout
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = LCD_H_ACTIVE,
  parameter int unsigned H_SYNC   = LCD_H_SYNC,
  parameter int unsigned H_BP     = LCD_H_BP,
  parameter int unsigned H_FP     = LCD_H_FP,
  parameter int unsigned V_ACTIVE = LCD_V_ACTIVE,
  parameter int unsigned V_SYNC   = LCD_V_SYNC,
  parameter int unsigned V_BP     = LCD_V_BP,
  parameter int unsigned V_FP     = LCD_V_FP,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        PixelClk,
  input  logic        nRST,
  input  logic [15:0] pix_data,
  input  logic        pix_sof,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        err_clr,
  output logic        LCD_HSYNC,
  output logic        LCD_VSYNC,
  output logic        LCD_DE,
  output logic [4:0]  LCD_R,
  output logic [5:0]  LCD_G,
  output logic [4:0]  LCD_B,
  output logic        frame_start,
  output logic        underrun,
  output logic        misalign
);

  logic in_active, is_fap, hsync_n, vsync_n, frame0;

  lcd_hv_counter #(
    .H_ACTIVE (H_ACTIVE), .H_SYNC (H_SYNC), .H_BP (H_BP), .H_FP (H_FP),
    .V_ACTIVE (V_ACTIVE), .V_SYNC (V_SYNC), .V_BP (V_BP), .V_FP (V_FP)
  ) u_hv (
    .clk       (PixelClk),
    .rst_n     (nRST),
    .in_active (in_active),
    .is_fap    (is_fap),
    .hsync_n   (hsync_n),
    .vsync_n   (vsync_n),
    .frame0    (frame0)
  );

  scan_state_e state_q, state_d;
  logic        misplaced, show, set_ur, set_ma;

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) state_q <= SEEK;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEEK:    if (is_fap && pix_valid && pix_sof) state_d = RUN;
      RUN:     if (in_active && (!pix_valid || (pix_sof != is_fap))) state_d = SEEK;
      default: state_d = SEEK;
    endcase
  end

  // While seeking, non-sof beats are flushed anywhere; a sof beat waits for the FAP.
  always_comb begin
    pix_ready = 1'b0;
    misplaced = 1'b0;
    show      = 1'b0;
    set_ur    = 1'b0;
    set_ma    = 1'b0;
    case (state_q)
      SEEK: begin
        pix_ready = !pix_sof || is_fap;
        show      = is_fap && pix_valid && pix_sof;
      end
      RUN: begin
        if (in_active) begin
          misplaced = pix_sof != is_fap;
          pix_ready = !misplaced;
          show      = pix_valid && !misplaced;
          set_ma    = pix_valid && misplaced;
          set_ur    = !pix_valid;
        end
      end
      default: ;
    endcase
  end

  logic    hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;
  logic    underrun_q, underrun_d, misalign_q, misalign_d;
  rgb565_t rgb_q, rgb_d;

  always_comb begin
    hsync_d    = hsync_n ^ SYNC_POL;
    vsync_d    = vsync_n ^ SYNC_POL;
    de_d       = in_active;
    fs_d       = frame0;
    rgb_d      = show ? rgb565_t'(pix_data) : '0;
    underrun_d = set_ur || (underrun_q && !err_clr);
    misalign_d = set_ma || (misalign_q && !err_clr);
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      hsync_q    <= !SYNC_POL;
      vsync_q    <= !SYNC_POL;
      de_q       <= 1'b0;
      fs_q       <= 1'b0;
      rgb_q      <= '0;
      underrun_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      de_q       <= de_d;
      fs_q       <= fs_d;
      rgb_q      <= rgb_d;
      underrun_q <= underrun_d;
      misalign_q <= misalign_d;
    end
  end

  assign LCD_HSYNC   = hsync_q;
  assign LCD_VSYNC   = vsync_q;
  assign LCD_DE      = de_q;
  assign LCD_R       = rgb_q.r;
  assign LCD_G       = rgb_q.g;
  assign LCD_B       = rgb_q.b;
  assign frame_start = fs_q;
  assign underrun    = underrun_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_lcd_rgb_scanout.sv
// Scoreboard bench for lcd_rgb_scanout on a 7x6 raster (4x3 visible).
module tb_lcd_rgb_scanout;

  localparam int H_TOT = 7;
  localparam int F_TOT = 42;

  logic        PixelClk = 1'b0;
  logic        nRST = 1'b1;
  logic [15:0] pix_data = '0;
  logic        pix_sof = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        err_clr = 1'b0;
  logic        LCD_HSYNC, LCD_VSYNC, LCD_DE;
  logic [4:0]  LCD_R;
  logic [5:0]  LCD_G;
  logic [4:0]  LCD_B;
  logic        frame_start, underrun, misalign;

  lcd_rgb_scanout #(
    .H_ACTIVE (4), .H_SYNC (1), .H_BP (1), .H_FP (1),
    .V_ACTIVE (3), .V_SYNC (1), .V_BP (1), .V_FP (1),
    .SYNC_POL (1'b0)
  ) dut (
    .PixelClk    (PixelClk),
    .nRST        (nRST),
    .pix_data    (pix_data),
    .pix_sof     (pix_sof),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .err_clr     (err_clr),
    .LCD_HSYNC   (LCD_HSYNC),
    .LCD_VSYNC   (LCD_VSYNC),
    .LCD_DE      (LCD_DE),
    .LCD_R       (LCD_R),
    .LCD_G       (LCD_G),
    .LCD_B       (LCD_B),
    .frame_start (frame_start),
    .underrun    (underrun),
    .misalign    (misalign)
  );

  always #5 PixelClk = ~PixelClk;

  typedef struct packed {
    logic        sof;
    logic [15:0] data;
  } beat_t;

  beat_t       src_q[$];
  logic [15:0] sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          pos = 0;
  bit          have_out = 1'b0;
  bit          gap_en = 1'b0;
  bit          gap_done = 1'b0;
  logic [15:0] gap_val = '0;
  int          clr_pos = -1;
  bit          clr_force = 1'b0;
  int          cnt_hs, cnt_vs, cnt_de, cnt_fs;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_src_frame(input logic [15:0] base);
    for (int i = 0; i < 12; i++) src_q.push_back('{sof: (i == 0), data: base + 16'(i)});
  endtask

  task automatic push_exp(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(base + 16'(i));
  endtask

  task automatic push_black(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(16'h0000);
  endtask

  task automatic drive_inputs();
    if (src_q.size() > 0) begin
      pix_valid = 1'b1;
      pix_data  = src_q[0].data;
      pix_sof   = src_q[0].sof;
      if (gap_en && !gap_done && src_q[0].data == gap_val) begin
        pix_valid = 1'b0;
        gap_done  = 1'b1;
      end
    end else begin
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      pix_data  = '0;
    end
    err_clr = clr_force || (pos == clr_pos);
  endtask

  // Outputs seen now belong to raster position p (one cycle of latency).
  task automatic check_outputs(input int p);
    int          f, h, v;
    bit          de;
    logic [15:0] rgb, exp_rgb;
    f   = p % F_TOT;
    h   = f % H_TOT;
    v   = f / H_TOT;
    de  = (h >= 2) && (h < 6) && (v >= 2) && (v < 5);
    rgb = {LCD_R, LCD_G, LCD_B};
    check_val("hsync", LCD_HSYNC, h != 0);
    check_val("vsync", LCD_VSYNC, v != 0);
    check_val("de", LCD_DE, de);
    check_val("frame_start", frame_start, f == 0);
    if (de) begin
      exp_rgb = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hDEAD;
      check_val("rgb", rgb, exp_rgb);
    end else begin
      check_val("rgb_blank", rgb, 0);
    end
    cnt_hs += !LCD_HSYNC;
    cnt_vs += !LCD_VSYNC;
    cnt_de += LCD_DE;
    cnt_fs += frame_start;
  endtask

  task automatic cycle();
    bit fire;
    drive_inputs();
    #1;
    if (have_out) check_outputs(pos - 1);
    fire = pix_valid && pix_ready;
    @(posedge PixelClk);
    if (fire) void'(src_q.pop_front());
    have_out = 1'b1;
    pos++;
    @(negedge PixelClk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    #1;
    check_val("rst_hsync", LCD_HSYNC, 1);
    check_val("rst_vsync", LCD_VSYNC, 1);
    check_val("rst_de", LCD_DE, 0);
    check_val("rst_rgb", {LCD_R, LCD_G, LCD_B}, 0);
    check_val("rst_frame_start", frame_start, 0);
    check_val("rst_underrun", underrun, 0);
    check_val("rst_misalign", misalign, 0);
    repeat (2) @(posedge PixelClk);
    @(negedge PixelClk);
    nRST      = 1'b1;
    pos       = 0;
    have_out  = 1'b0;
    sb_q.delete();
    gap_en    = 1'b0;
    gap_done  = 1'b0;
    clr_pos   = -1;
    clr_force = 1'b0;
  endtask

  initial begin
    #3;
    // Timing only, no stream: two frames of blanking-coloured raster.
    apply_reset();
    cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_fs = 0;
    push_black(24);
    run(84);
    check_val("hsync_lows", cnt_hs, 12);
    check_val("vsync_lows", cnt_vs, 14);
    check_val("de_cycles", cnt_de, 24);
    check_val("frame_starts", cnt_fs, 2);
    check_val("t1_underrun", underrun, 0);
    check_val("t1_misalign", misalign, 0);

    // Continuous stream, two aligned frames.
    apply_reset();
    push_src_frame(16'h0001);
    push_src_frame(16'h0001);
    push_exp(16'h0001, 12);
    push_exp(16'h0001, 12);
    run(84);
    check_val("t2_sb_left", sb_q.size(), 0);
    check_val("t2_src_left", src_q.size(), 0);
    check_val("t2_underrun", underrun, 0);
    check_val("t2_misalign", misalign, 0);

    // Stale beats ahead of a frame are flushed before the FAP.
    apply_reset();
    for (int i = 0; i < 5; i++) src_q.push_back('{sof: 1'b0, data: 16'h00A0 + 16'(i)});
    push_src_frame(16'h0001);
    push_exp(16'h0001, 12);
    run(42);
    check_val("t3_sb_left", sb_q.size(), 0);
    check_val("t3_src_left", src_q.size(), 0);
    check_val("t3_underrun", underrun, 0);
    check_val("t3_misalign", misalign, 0);

    // Source stalls at pixel 6: black for the rest of the frame, relock next frame.
    apply_reset();
    push_src_frame(16'h0001);
    push_src_frame(16'h0001);
    gap_en  = 1'b1;
    gap_val = 16'h0007;
    push_exp(16'h0001, 6);
    push_black(6);
    push_exp(16'h0001, 12);
    run(84);
    check_val("t4_sb_left", sb_q.size(), 0);
    check_val("t4_src_left", src_q.size(), 0);
    check_val("t4_underrun", underrun, 1);
    check_val("t4_misalign", misalign, 0);

    // Early sof on pixel 3 while err_clr is asserted in that same cycle.
    apply_reset();
    src_q.push_back('{sof: 1'b1, data: 16'h0001});
    src_q.push_back('{sof: 1'b0, data: 16'h0002});
    src_q.push_back('{sof: 1'b0, data: 16'h0003});
    push_src_frame(16'h0011);
    push_exp(16'h0001, 3);
    push_black(9);
    push_exp(16'h0011, 12);
    clr_pos = 19;
    run(84);
    check_val("t5_sb_left", sb_q.size(), 0);
    check_val("t5_src_left", src_q.size(), 0);
    check_val("t5_misalign", misalign, 1);
    check_val("t5_underrun", underrun, 0);
    clr_force = 1'b1;
    cycle();
    clr_force = 1'b0;
    check_val("t5_misalign_clr", misalign, 0);

    // Reset while the counters sit at h=3,v=3 mid-frame.
    apply_reset();
    push_src_frame(16'h0001);
    push_exp(16'h0001, 12);
    run(24);
    apply_reset();
    push_src_frame(16'h0021);
    push_exp(16'h0021, 12);
    run(42);
    check_val("t6_sb_left", sb_q.size(), 0);
    check_val("t6_src_left", src_q.size(), 0);
    check_val("t6_underrun", underrun, 0);
    check_val("t6_misalign", misalign, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
